// File: rtl/ppu_vram_arb.sv
// PPU video memory (CHR RAM, mirrored nametable CIRAM, palette RAM) shared by render and host ports.
// Optional CHR write-protect is enabled by defining PPU_VRAM_CHR_WP_EN.
module ppu_vram_arb #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHR_AW   = 13,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_mirror_mode,
    input  logic              i_rd_req,
    input  logic [15:0]       i_rd_addr,
    output logic              o_rd_stall,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [15:0]       i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_ack,
    output logic [DATA_W-1:0] o_host_rdata,
    input  logic              i_chr_wp
);

    localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    typedef enum logic [1:0] {
        RegChr,
        RegNt,
        RegPal
    } region_e;

    logic [DATA_W-1:0] r_chr_mem [2**CHR_AW];
    logic [DATA_W-1:0] r_nt_mem  [2048];
    logic [DATA_W-1:0] r_pal_mem [32];

    logic [WaitW-1:0]  r_wait_cnt;
    logic [WaitW-1:0]  w_wait_cnt_d;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_host_ack;
    logic [DATA_W-1:0] r_host_rdata;

    logic              w_host_pend;
    logic              w_host_grant;
    logic              w_rd_grant;
    logic [13:0]       w_a;
    region_e           w_region;
    logic [CHR_AW-1:0] w_chr_idx;
    logic              w_page;
    logic [10:0]       w_nt_idx;
    logic [4:0]        w_pal_idx;
    logic [DATA_W-1:0] w_rdata;
    logic              w_we;
    logic              w_chr_we;
    logic              w_nt_we;
    logic              w_pal_we;
    logic              w_unused_bits;

    // The request still high during its own ack cycle is the one just served.
    assign w_host_pend  = i_host_req & ~r_host_ack;
    assign w_host_grant = w_host_pend & (~i_rd_req | (r_wait_cnt == WaitMax));
    assign w_rd_grant   = i_rd_req & ~w_host_grant;
    assign o_rd_stall   = i_rd_req & w_host_grant;

    always_comb begin
        w_wait_cnt_d = r_wait_cnt;
        if (w_host_grant || !w_host_pend) begin
            w_wait_cnt_d = '0;
        end else if (w_rd_grant && (r_wait_cnt != WaitMax)) begin
            w_wait_cnt_d = r_wait_cnt + WaitW'(1);
        end
    end

    assign w_a = w_host_grant ? i_host_addr[13:0] : i_rd_addr[13:0];

    always_comb begin
        w_region = RegChr;
        if (w_a[13]) begin
            w_region = (w_a[13:8] == 6'h3F) ? RegPal : RegNt;
        end
        w_page = 1'b0;
        unique case (i_mirror_mode)
            2'd0:    w_page = w_a[11];
            2'd1:    w_page = w_a[10];
            2'd2:    w_page = 1'b0;
            default: w_page = 1'b1;
        endcase
    end

    assign w_chr_idx = w_a[CHR_AW-1:0];
    assign w_nt_idx  = {w_page, w_a[9:0]};
    // Backdrop entries 0x10/14/18/1C share storage with 0x00/04/08/0C.
    assign w_pal_idx = {w_a[4] & (|w_a[1:0]), w_a[3:0]};

    always_comb begin
        w_rdata = '0;
        case (w_region)
            RegChr:  w_rdata = r_chr_mem[w_chr_idx];
            RegNt:   w_rdata = r_nt_mem[w_nt_idx];
            default: w_rdata = r_pal_mem[w_pal_idx];
        endcase
    end

    assign w_we     = w_host_grant & i_host_we;
    assign w_nt_we  = w_we & (w_region == RegNt);
    assign w_pal_we = w_we & (w_region == RegPal);
`ifdef PPU_VRAM_CHR_WP_EN
    assign w_chr_we      = w_we & (w_region == RegChr) & ~i_chr_wp;
    assign w_unused_bits = ^{i_rd_addr[15:14], i_host_addr[15:14]};
`else
    assign w_chr_we      = w_we & (w_region == RegChr);
    assign w_unused_bits = ^{i_rd_addr[15:14], i_host_addr[15:14], i_chr_wp};
`endif

    always_ff @(posedge clk) begin
        if (w_chr_we) begin
            r_chr_mem[w_chr_idx] <= i_host_wdata;
        end
        if (w_nt_we) begin
            r_nt_mem[w_nt_idx] <= i_host_wdata;
        end
        if (w_pal_we) begin
            r_pal_mem[w_pal_idx] <= i_host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt   <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_d;
            r_rd_valid <= w_rd_grant;
            r_host_ack <= w_host_grant;
            if (w_rd_grant) begin
                r_rd_data <= w_rdata;
            end
            if (w_host_grant && !i_host_we) begin
                r_host_rdata <= w_rdata;
            end
        end
    end

    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = r_rd_data;
    assign o_host_ack   = r_host_ack;
    assign o_host_rdata = r_host_rdata;

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed scoreboard bench for ppu_vram_arb: mirroring, palette aliasing, starvation guard,
// latency, reset mid-access and CHR write-protect (behaviour depends on PPU_VRAM_CHR_WP_EN).
module tb_ppu_vram_arb;

    typedef struct packed {
        logic       chk;
        logic [7:0] d;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] mirror_mode;
    logic       rd_req;
    logic [15:0] rd_addr;
    logic       rd_stall;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       host_req;
    logic       host_we;
    logic [15:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       chr_wp;

    exp_t q_rd[$];
    exp_t q_host[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    ppu_vram_arb #(
        .DATA_W  (8),
        .CHR_AW  (13),
        .MAX_WAIT(4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_mirror_mode(mirror_mode),
        .i_rd_req    (rd_req),
        .i_rd_addr   (rd_addr),
        .o_rd_stall  (rd_stall),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data),
        .i_host_req  (host_req),
        .i_host_we   (host_we),
        .i_host_addr (host_addr),
        .i_host_wdata(host_wdata),
        .o_host_ack  (host_ack),
        .o_host_rdata(host_rdata),
        .i_chr_wp    (chr_wp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score any completions against the queues.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rd_valid) begin
            if (q_rd.size() == 0) begin
                check("rd_spurious", {31'b0, rd_valid}, 32'd0);
            end else begin
                e = q_rd.pop_front();
                check("rd_data", {24'b0, rd_data}, {24'b0, e.d});
            end
        end
        if (host_ack) begin
            if (q_host.size() == 0) begin
                check("host_ack_spurious", {31'b0, host_ack}, 32'd0);
            end else begin
                e = q_host.pop_front();
                if (e.chk) check("host_rdata", {24'b0, host_rdata}, {24'b0, e.d});
            end
        end
    endtask

    task automatic host_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                               input logic [7:0] exp);
        bit acked = 0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wd;
        q_host.push_back('{chk: ~we, d: exp});
        for (int i = 0; i < 20; i++) begin
            tick();
            if (host_ack) begin
                acked = 1;
                break;
            end
        end
        host_req = 1'b0;
        if (!acked) begin
            check("host_timeout", {31'b0, host_ack}, 32'd1);
            q_host.delete();
        end
    endtask

    task automatic render_read(input logic [15:0] addr, input logic [7:0] exp);
        bit accepted = 0;
        bit stalled;
        rd_req  = 1'b1;
        rd_addr = addr;
        q_rd.push_back('{chk: 1'b1, d: exp});
        for (int i = 0; i < 20; i++) begin
            #1;
            stalled = rd_stall;
            tick();
            if (!stalled) begin
                accepted = 1;
                break;
            end
        end
        rd_req = 1'b0;
        check("rd_valid_latency", {31'b0, rd_valid}, 32'd1);
        if (!accepted) q_rd.delete();
    endtask

    initial begin
        rst         = 1'b1;
        mirror_mode = 2'd0;
        rd_req      = 1'b0;
        rd_addr     = '0;
        host_req    = 1'b0;
        host_we     = 1'b0;
        host_addr   = '0;
        host_wdata  = '0;
        chr_wp      = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset_rd_data", {24'b0, rd_data}, 32'd0);
        check("reset_host_ack", {31'b0, host_ack}, 32'd0);
        check("reset_host_rdata", {24'b0, host_rdata}, 32'd0);
        check("reset_rd_stall", {31'b0, rd_stall}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Horizontal / vertical / single-screen mirroring.
        mirror_mode = 2'd0;
        host_access(1'b1, 16'h2C05, 8'h5A, 8'h00);
        host_access(1'b1, 16'h2005, 8'hA5, 8'h00);
        render_read(16'h2405, 8'hA5);
        render_read(16'h2805, 8'h5A);
        mirror_mode = 2'd1;
        render_read(16'h2805, 8'hA5);
        render_read(16'h2C05, 8'h5A);
        mirror_mode = 2'd2;
        render_read(16'h2C05, 8'hA5);
        mirror_mode = 2'd3;
        render_read(16'h2005, 8'h5A);
        render_read(16'h3005, 8'h5A);
        host_access(1'b0, 16'hE405, 8'h00, 8'h5A);

        // Palette backdrop aliasing.
        host_access(1'b1, 16'h3F01, 8'h22, 8'h00);
        host_access(1'b1, 16'h3F10, 8'h3F, 8'h00);
        render_read(16'h3F00, 8'h3F);
        render_read(16'h3F10, 8'h3F);
        host_access(1'b1, 16'h3F11, 8'h11, 8'h00);
        render_read(16'h3F01, 8'h22);
        host_access(1'b0, 16'h3F11, 8'h00, 8'h11);
        host_access(1'b0, 16'h3F1C, 8'h00, 8'hxx);

        // Read-after-write on consecutive host grants, CHR aliasing.
        host_access(1'b1, 16'h0123, 8'hC3, 8'h00);
        host_access(1'b0, 16'h0123, 8'h00, 8'hC3);
        render_read(16'h0123, 8'hC3);
        render_read(16'h4123, 8'hC3);

        // Starvation guard: render held busy, host wins on the fifth contested cycle.
        rd_addr = 16'h0123;
        rd_req  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q_rd.push_back('{chk: 1'b1, d: 8'hC3});
            tick();
        end
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 16'h3F00;
        q_host.push_back('{chk: 1'b1, d: 8'h3F});
        for (int k = 1; k <= 5; k++) begin
            #1;
            check($sformatf("stall_cycle%0d", k), {31'b0, rd_stall}, {31'b0, (k == 5)});
            if (!rd_stall) q_rd.push_back('{chk: 1'b1, d: 8'hC3});
            tick();
            check($sformatf("ack_cycle%0d", k), {31'b0, host_ack}, {31'b0, (k == 5)});
        end
        check("rd_valid_during_host", {31'b0, rd_valid}, 32'd0);
        host_req = 1'b0;
        #1;
        check("stall_after_host", {31'b0, rd_stall}, 32'd0);
        q_rd.push_back('{chk: 1'b1, d: 8'hC3});
        tick();
        check("rd_resumes", {31'b0, rd_valid}, 32'd1);
        rd_req = 1'b0;
        tick();

        // Reset asserted while a host read is in flight.
        mirror_mode = 2'd0;
        host_req    = 1'b1;
        host_we     = 1'b0;
        host_addr   = 16'h2005;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_host_ack", {31'b0, host_ack}, 32'd0);
        check("midrst_host_rdata", {24'b0, host_rdata}, 32'd0);
        check("midrst_rd_data", {24'b0, rd_data}, 32'd0);
        check("midrst_rd_valid", {31'b0, rd_valid}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        host_access(1'b0, 16'h2005, 8'h00, 8'hA5);
        for (int k = 0; k < 3; k++) tick();
        check("no_double_ack", {31'b0, host_ack}, 32'd0);

        // CHR write-protect.
        host_access(1'b1, 16'h0010, 8'h33, 8'h00);
        chr_wp = 1'b1;
        host_access(1'b1, 16'h0010, 8'h77, 8'h00);
`ifdef PPU_VRAM_CHR_WP_EN
        host_access(1'b0, 16'h0010, 8'h00, 8'h33);
        host_access(1'b1, 16'h2010, 8'h44, 8'h00);
        render_read(16'h2010, 8'h44);
`else
        host_access(1'b0, 16'h0010, 8'h00, 8'h77);
`endif
        chr_wp = 1'b0;
        host_access(1'b1, 16'h0010, 8'h77, 8'h00);
        render_read(16'h0010, 8'h77);

        tick();
        check("rd_queue_drained", q_rd.size(), 32'd0);
        check("host_queue_drained", q_host.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
